// File: rtl/fifo_drain_packer.sv
// Drains a fixed-latency byte FIFO and packs LANES bytes per output word.
// A flush request emits whatever is buffered as a partial word marked m_last.
module fifo_drain_packer #(
  parameter int DIN_W = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rd,
  input  logic [DIN_W-1:0]         dout,
  input  logic                     empty,
  input  logic                     flush,
  output logic [DIN_W*LANES-1:0]   m_data,
  output logic [LANES-1:0]         m_keep,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int IW = $clog2(LANES);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(LANES);

  typedef enum logic [1:0] {FILL, FLUSH_WAIT, FLUSH_EMIT} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_base;
  logic                     pend_q, pend_d;
  logic                     flush_req_q, flush_req_d;
  logic [DIN_W*LANES-1:0]   acc_q, acc_d;
  logic [DIN_W*LANES-1:0]   m_data_q, m_data_d;
  logic [LANES-1:0]         m_keep_q, m_keep_d;
  logic                     m_last_q, m_last_d;
  logic                     m_valid_q, m_valid_d;
  logic [LANES-1:0]         part_keep;
  logic [IW-1:0]            wr_lane;
  logic                     out_free;

  function automatic logic [LANES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [LANES-1:0] k;
    for (int i = 0; i < LANES; i++) k[i] = (CW'(i) < n);
    return k;
  endfunction

  function automatic logic [DIN_W*LANES-1:0] mask_lanes(
    input logic [DIN_W*LANES-1:0] data,
    input logic [LANES-1:0]       keep
  );
    logic [DIN_W*LANES-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*DIN_W +: DIN_W] = keep[i] ? data[i*DIN_W +: DIN_W] : '0;
    return r;
  endfunction

  always_comb begin
    out_free    = !m_valid_q || m_ready;
    // cnt+pend bound guarantees an in-flight byte always has a free lane
    rd          = rst && !empty && !flush_req_q &&
                  (({1'b0, cnt_q} + {{CW{1'b0}}, pend_q}) < {1'b0, FULL});
    part_keep   = keep_mask(cnt_q);
    state_d     = state_q;
    flush_req_d = flush_req_q;
    acc_d       = acc_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;
    cnt_base    = cnt_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (!flush_req_q && cnt_q == FULL && out_free) begin
      m_data_d  = acc_q;
      m_keep_d  = '1;
      m_last_d  = 1'b0;
      m_valid_d = 1'b1;
      cnt_base  = '0;
    end

    unique case (state_q)
      FILL: begin
        if (flush) begin
          state_d     = FLUSH_WAIT;
          flush_req_d = 1'b1;
        end
      end
      FLUSH_WAIT: begin
        if (!pend_q && out_free) state_d = FLUSH_EMIT;
      end
      FLUSH_EMIT: begin
        if (cnt_q != '0) begin
          m_data_d  = mask_lanes(acc_q, part_keep);
          m_keep_d  = part_keep;
          m_last_d  = 1'b1;
          m_valid_d = 1'b1;
          cnt_base  = '0;
        end
        state_d     = FILL;
        flush_req_d = 1'b0;
      end
      default: state_d = FILL;
    endcase

    // A byte landing on a word-load cycle goes to lane 0 of the fresh word
    wr_lane = cnt_base[IW-1:0];
    cnt_d   = cnt_base;
    if (pend_q) begin
      acc_d[wr_lane*DIN_W +: DIN_W] = dout;
      cnt_d = cnt_base + CW'(1);
    end
    pend_d = rd;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      flush_req_q <= flush_req_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: directed vector table, hand-written flush/reset
// sequences, and a randomized run scored against a FIFO-order byte model.
module tb_fifo_drain_packer;
  localparam int DIN_W = 8;
  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd;
  logic [7:0]  dout = 8'h00;
  logic        empty = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_drain_packer #(.DIN_W(DIN_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .rd(rd), .dout(dout), .empty(empty), .flush(flush),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  typedef struct packed {
    int          nb;
    logic [71:0] bytes;
    logic        hold;
    logic        fl;
    int          left;
    int          nw;
    int          run;
    logic [31:0] d0; logic [3:0] k0; logic l0;
    logic [31:0] d1; logic [3:0] k1; logic l1;
  } vec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] fifo[$];
  logic [7:0] sent[$];
  logic [7:0] recv[$];
  word_t      words[$];
  bit         gate = 1'b0;
  bit         toggle = 1'b0;
  int         run_cur = 0;
  int         run_max = 0;
  bit         stall_prev = 1'b0;
  logic [31:0] sd;
  logic [3:0]  sk;
  logic        sl;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // FIFO model: read data appears one cycle after the strobe
  always @(posedge clk) begin
    chk("rd_while_empty", 64'(rd & empty), 64'(0));
    chk("rd_in_reset", 64'(rd & ~rst), 64'(0));
    if (rd === 1'b1) begin
      if (fifo.size() > 0) dout <= fifo.pop_front();
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
    end else begin
      run_cur = 0;
    end
  end

  // Output monitor: hold-stability, word shape, byte collection
  always @(posedge clk) begin
    if (rst === 1'b1 && stall_prev) begin
      chk("hold_valid", 64'(m_valid), 64'(1));
      chk("hold_data", 64'(m_data), 64'(sd));
      chk("hold_keep", 64'(m_keep), 64'(sk));
      chk("hold_last", 64'(m_last), 64'(sl));
    end
    if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      words.push_back('{m_data, m_keep, m_last});
      chk("keep_shape", 64'(m_keep inside {4'h1, 4'h3, 4'h7, 4'hF}), 64'(1));
      chk("unused_lanes_zero", 64'(m_data & ~lane_mask(m_keep)), 64'(0));
      if (m_keep != 4'hF) chk("partial_last", 64'(m_last), 64'(1));
      for (int i = 0; i < LANES; i++)
        if (m_keep[i]) recv.push_back(m_data[i*8 +: 8]);
    end
    stall_prev = (rst === 1'b1) && (m_valid === 1'b1) && (m_ready === 1'b0);
    sd = m_data; sk = m_keep; sl = m_last;
  end

  task automatic upd_empty();
    empty = gate || (fifo.size() == 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (toggle) gate = ~gate;
    upd_empty();
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    sent.push_back(b);
    upd_empty();
  endtask

  task automatic clear_all();
    fifo.delete(); sent.delete(); recv.delete(); words.delete();
    run_max = 0;
    upd_empty();
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; gate = 1'b0; toggle = 1'b0; m_ready = 1'b0;
    repeat (2) cyc();
    clear_all();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 72'h44332211, 1'b0, 1'b0, 0, 1, 4,
                32'h44332211, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0};
    vecs[1] = '{9, 72'h09_0807060504030201, 1'b1, 1'b0, 1, 2, 4,
                32'h04030201, 4'hF, 1'b0, 32'h08070605, 4'hF, 1'b0};
    vecs[2] = '{3, 72'hCCBBAA, 1'b0, 1'b1, 0, 1, 3,
                32'h00CCBBAA, 4'h7, 1'b1, 32'h0, 4'h0, 1'b0};
    vecs[3] = '{8, 72'h0807060504030201, 1'b1, 1'b1, 0, 2, 4,
                32'h04030201, 4'hF, 1'b0, 32'h08070605, 4'hF, 1'b1};
    vecs[4] = '{1, 72'h5A, 1'b0, 1'b1, 0, 1, 1,
                32'h0000005A, 4'h1, 1'b1, 32'h0, 4'h0, 1'b0};
    vecs[5] = '{0, 72'h0, 1'b0, 1'b1, 0, 0, 0,
                32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0};
    vecs[6] = '{2, 72'h2211, 1'b1, 1'b1, 0, 1, 2,
                32'h00002211, 4'h3, 1'b1, 32'h0, 4'h0, 1'b0};
    vecs[7] = '{6, 72'h060504030201, 1'b0, 1'b1, 0, 2, 4,
                32'h04030201, 4'hF, 1'b0, 32'h00000605, 4'h3, 1'b1};

    rst = 1'b0;
    repeat (2) cyc();
    chk("reset_valid", 64'(m_valid), 64'(0));
    chk("reset_keep", 64'(m_keep), 64'(0));
    chk("reset_data", 64'(m_data), 64'(0));
    chk("reset_last", 64'(m_last), 64'(0));

    for (int v = 0; v < 8; v++) begin
      do_reset();
      m_ready = ~vecs[v].hold;
      for (int b = 0; b < vecs[v].nb; b++) push(vecs[v].bytes[b*8 +: 8]);
      repeat (16) cyc();
      chk("vec_left", 64'(fifo.size()), 64'(vecs[v].left));
      if (vecs[v].fl) begin
        flush = 1'b1; cyc(); flush = 1'b0;
      end
      m_ready = 1'b1;
      repeat (12) cyc();
      chk("vec_nwords", 64'(words.size()), 64'(vecs[v].nw));
      chk("vec_rd_run", 64'(run_max), 64'(vecs[v].run));
      if (vecs[v].nw > 0 && words.size() > 0) begin
        chk("vec_w0_data", 64'(words[0].d), 64'(vecs[v].d0));
        chk("vec_w0_keep", 64'(words[0].k), 64'(vecs[v].k0));
        chk("vec_w0_last", 64'(words[0].l), 64'(vecs[v].l0));
      end
      if (vecs[v].nw > 1 && words.size() > 1) begin
        chk("vec_w1_data", 64'(words[1].d), 64'(vecs[v].d1));
        chk("vec_w1_keep", 64'(words[1].k), 64'(vecs[v].k1));
        chk("vec_w1_last", 64'(words[1].l), 64'(vecs[v].l1));
      end
    end

    // Flush with a partial word: reads stay off through wait/emit
    do_reset();
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (10) cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    push(8'hDD);
    #1;
    chk("rd_flush_wait", 64'(rd), 64'(0));
    cyc();
    chk("rd_flush_emit", 64'(rd), 64'(0));
    cyc();
    chk("rd_after_flush", 64'(rd), 64'(1));
    chk("flush_valid", 64'(m_valid), 64'(1));
    chk("flush_data", 64'(m_data), 64'(32'h00CCBBAA));
    chk("flush_keep", 64'(m_keep), 64'(4'h7));
    chk("flush_last", 64'(m_last), 64'(1));

    // Empty flush: no word, back to reading two cycles later
    do_reset();
    m_ready = 1'b1;
    flush = 1'b1; cyc(); flush = 1'b0;
    push(8'h77);
    #1;
    chk("empty_flush_rd0", 64'(rd), 64'(0));
    cyc();
    chk("empty_flush_rd1", 64'(rd), 64'(0));
    chk("empty_flush_valid1", 64'(m_valid), 64'(0));
    cyc();
    chk("empty_flush_rd2", 64'(rd), 64'(1));
    chk("empty_flush_valid2", 64'(m_valid), 64'(0));
    repeat (4) cyc();
    chk("empty_flush_valid3", 64'(m_valid), 64'(0));
    chk("empty_flush_words", 64'(words.size()), 64'(0));

    // Reset mid-operation: stalled word, cnt=2 and a byte in flight
    do_reset();
    m_ready = 1'b0;
    for (int b = 1; b <= 7; b++) push(8'(b));
    repeat (9) cyc();
    chk("pre_reset_valid", 64'(m_valid), 64'(1));
    push(8'h08);
    rst = 1'b0;
    #1;
    chk("rd_during_reset", 64'(rd), 64'(0));
    cyc();
    chk("mid_reset_valid", 64'(m_valid), 64'(0));
    chk("mid_reset_data", 64'(m_data), 64'(0));
    chk("mid_reset_keep", 64'(m_keep), 64'(0));
    chk("mid_reset_last", 64'(m_last), 64'(0));
    chk("mid_reset_rd", 64'(rd), 64'(0));
    clear_all();
    rst = 1'b1;
    m_ready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (16) cyc();
    chk("post_reset_nwords", 64'(words.size()), 64'(1));
    if (words.size() > 0) begin
      chk("post_reset_data", 64'(words[0].d), 64'(32'hA4A3A2A1));
      chk("post_reset_keep", 64'(words[0].k), 64'(4'hF));
      chk("post_reset_last", 64'(words[0].l), 64'(0));
    end

    // Randomized: toggling empty, random backpressure and flushes
    do_reset();
    toggle = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0 && fifo.size() < 12) push(8'($urandom));
      flush = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush = 1'b0;
    toggle = 1'b0;
    gate = 1'b0;
    upd_empty();
    m_ready = 1'b1;
    repeat (30) cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    repeat (10) cyc();
    chk("rand_byte_count", 64'(recv.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < recv.size(); i++)
      chk("rand_byte_order", 64'(recv[i]), 64'(sent[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
